// File: rtl/case4_pkg.sv
// Shared definitions for the case4 netlist driver: pin maps, FSM states and
// the reference function used by both the RTL and the bench scoreboard.
package case4_pkg;

  localparam int NUM_IN  = 7;
  localparam int NUM_OUT = 3;

  localparam int VEC_A = 6;
  localparam int VEC_B = 5;
  localparam int VEC_C = 4;
  localparam int VEC_D = 3;
  localparam int VEC_E = 2;
  localparam int VEC_F = 1;
  localparam int VEC_G = 0;

  localparam int RESP_X = 2;
  localparam int RESP_Y = 1;
  localparam int RESP_Z = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  function automatic logic [NUM_OUT-1:0] case4_golden(input logic [NUM_IN-1:0] v);
    logic [NUM_OUT-1:0] r;
    r[RESP_X] =   v[VEC_A] & v[VEC_B] & v[VEC_E];
    r[RESP_Y] = ~(v[VEC_B] & v[VEC_E] & v[VEC_D]);
    r[RESP_Z] = ~(v[VEC_C] & v[VEC_D] & v[VEC_E] & v[VEC_F] & v[VEC_G]);
    return r;
  endfunction

endpackage

// File: rtl/case4_golden_model.sv
// Combinational reference for the case4 netlist; swap this file to retarget
// the driver at another benchmark circuit.
module case4_golden_model
  import case4_pkg::*;
(
  input  logic [NUM_IN-1:0]  vec_i,
  output logic [NUM_OUT-1:0] resp_o
);

  assign resp_o = case4_golden(vec_i);

endmodule

// File: rtl/case4_vec_driver.sv
// Exhaustive stimulus driver and response checker for the case4 netlist:
// walks all 128 input vectors, compares responses with the golden model.
module case4_vec_driver
  import case4_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic [NUM_IN-1:0]  vec_o,
  input  logic [NUM_OUT-1:0] resp_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [7:0]         err_cnt_o,
  output logic [NUM_IN-1:0]  fail_vec_o,
  output logic [NUM_OUT-1:0] fail_resp_o
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam state_e HOLD_STATE = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_DRIVE;

  state_e             state_q, state_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [NUM_IN-1:0]  vec_q, vec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [7:0]         err_q, err_d;
  logic [NUM_IN-1:0]  fvec_q, fvec_d;
  logic [NUM_OUT-1:0] fresp_q, fresp_d;
  logic [NUM_OUT-1:0] gold;
  logic               mismatch;

  case4_golden_model u_gold (
    .vec_i  (vec_q),
    .resp_o (gold)
  );

  assign mismatch = (resp_i != gold);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fvec_d   = fvec_q;
    fresp_d  = fresp_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          vec_d    = '0;
          err_d    = '0;
          fvec_d   = '0;
          fresp_d  = '0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          settle_d = '0;
          state_d  = HOLD_STATE;
        end
      end
      S_DRIVE: begin
        if (settle_q == SETTLE_LAST) state_d = S_SAMPLE;
        else                         settle_d = settle_q + 1'b1;
      end
      S_SAMPLE: begin
        if (mismatch) begin
          // Error count of zero identifies the first mismatch of the run.
          if (err_q == 8'd0) begin
            fvec_d  = vec_q;
            fresp_d = resp_i;
          end
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
        if (vec_q == 7'h7F || (STOP_ON_FAIL && mismatch)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == 8'd0);
        end else begin
          vec_d    = vec_q + 7'd1;
          settle_d = '0;
          state_d  = HOLD_STATE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fvec_q   <= '0;
      fresp_q  <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fvec_q   <= fvec_d;
      fresp_q  <= fresp_d;
    end
  end

  assign vec_o       = vec_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_cnt_o   = err_q;
  assign fail_vec_o  = fvec_q;
  assign fail_resp_o = fresp_q;

endmodule

// File: tb/tb_case4_vec_driver.sv
// Directed bench: three driver instances (default, stop-on-fail, zero settle)
// each facing a netlist model with an optional stuck-at fault.
module tb_case4_vec_driver;
  import case4_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [3];
  logic [1:0] fault [3];  // 0 none, 1 x stuck-at-0, 2 z stuck-at-1
  logic [6:0] vec   [3];
  logic [2:0] resp  [3];
  logic       busy  [3];
  logic       done  [3];
  logic       pass  [3];
  logic [7:0] err   [3];
  logic [6:0] fvec  [3];
  logic [2:0] fresp [3];

  int tests = 0;
  int fails = 0;
  int cyc, bcnt, seen;

  always #5 clk = ~clk;

  function automatic logic [2:0] netlist(input logic [6:0] v, input logic [1:0] f);
    logic [2:0] r;
    r = case4_golden(v);
    if (f == 2'd1) r[RESP_X] = 1'b0;
    if (f == 2'd2) r[RESP_Z] = 1'b1;
    return r;
  endfunction

  assign resp[0] = netlist(vec[0], fault[0]);
  assign resp[1] = netlist(vec[1], fault[1]);
  assign resp[2] = netlist(vec[2], fault[2]);

  case4_vec_driver #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .vec_o(vec[0]), .resp_i(resp[0]),
    .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .err_cnt_o(err[0]),
    .fail_vec_o(fvec[0]), .fail_resp_o(fresp[0]));

  case4_vec_driver #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .vec_o(vec[1]), .resp_i(resp[1]),
    .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .err_cnt_o(err[1]),
    .fail_vec_o(fvec[1]), .fail_resp_o(fresp[1]));

  case4_vec_driver #(.SETTLE_CYCLES(0), .STOP_ON_FAIL(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start[2]), .vec_o(vec[2]), .resp_i(resp[2]),
    .busy_o(busy[2]), .done_o(done[2]), .pass_o(pass[2]), .err_cnt_o(err[2]),
    .fail_vec_o(fvec[2]), .fail_resp_o(fresp[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start on instance k, then count cycles from the start edge until
  // done_o is seen. A second start is injected at cycle midstart (if >= 0).
  task automatic run(input int k, input int midstart, output int c, output int b);
    @(negedge clk); start[k] = 1'b1;
    @(posedge clk);
    @(negedge clk); start[k] = 1'b0;
    chk("start_vec", vec[k], 0);
    chk("start_busy", busy[k], 1);
    chk("start_pass", pass[k], 0);
    c = 0;
    b = busy[k] ? 1 : 0;
    while (!done[k] && c < 2000) begin
      start[k] = (c == midstart);
      @(posedge clk); c++;
      @(negedge clk);
      if (busy[k]) b++;
    end
    start[k] = 1'b0;
    chk("done_seen", done[k], 1);
    chk("done_busy", busy[k], 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin start[i] = 1'b0; fault[i] = 2'd0; end
    repeat (3) @(negedge clk);
    chk("rst_vec",   vec[0],   0);
    chk("rst_busy",  busy[0],  0);
    chk("rst_done",  done[0],  0);
    chk("rst_pass",  pass[0],  0);
    chk("rst_err",   err[0],   0);
    chk("rst_fvec",  fvec[0],  0);
    chk("rst_fresp", fresp[0], 0);
    rst_n = 1'b1;

    // Correct netlist, default parameters
    run(0, -1, cyc, bcnt);
    chk("good_cycles", cyc, 256);
    chk("good_busy",   bcnt, 256);
    chk("good_pass",   pass[0], 1);
    chk("good_err",    err[0], 0);
    chk("good_vec",    vec[0], 7'h7F);
    repeat (3) @(negedge clk);
    chk("good_done_pulse", done[0], 0);
    chk("good_pass_held",  pass[0], 1);
    chk("good_vec_held",   vec[0], 7'h7F);

    // x stuck-at-0
    fault[0] = 2'd1;
    run(0, -1, cyc, bcnt);
    chk("xsa0_cycles", cyc, 256);
    chk("xsa0_err",    err[0], 16);
    chk("xsa0_fvec",   fvec[0], 7'h64);
    chk("xsa0_fresp",  fresp[0], 3'b011);
    chk("xsa0_pass",   pass[0], 0);

    // z stuck-at-1: vector 0x1F golden is 3'b010, faulty response 3'b011
    fault[0] = 2'd2;
    run(0, -1, cyc, bcnt);
    chk("zsa1_err",   err[0], 4);
    chk("zsa1_fvec",  fvec[0], 7'h1F);
    chk("zsa1_fresp", fresp[0], 3'b011);
    chk("zsa1_pass",  pass[0], 0);

    // Stop on first failure
    fault[1] = 2'd1;
    run(1, -1, cyc, bcnt);
    chk("stop_cycles", cyc, 202);
    chk("stop_err",    err[1], 1);
    chk("stop_fvec",   fvec[1], 7'h64);
    chk("stop_fresp",  fresp[1], 3'b011);
    chk("stop_pass",   pass[1], 0);
    chk("stop_vec",    vec[1], 7'h64);

    // Zero settle, second start mid-run ignored
    run(2, 50, cyc, bcnt);
    chk("s0_cycles", cyc, 128);
    chk("s0_busy",   bcnt, 128);
    chk("s0_pass",   pass[2], 1);
    // start while in DONE is ignored
    start[2] = 1'b1;
    @(posedge clk);
    @(negedge clk); start[2] = 1'b0;
    chk("done_start_busy", busy[2], 0);
    chk("done_start_pass", pass[2], 1);
    @(posedge clk);
    @(negedge clk);
    chk("done_start_idle", busy[2], 0);

    // Abort at vector 40 with z stuck-at-1 (one mismatch already captured)
    fault[0] = 2'd2;
    @(negedge clk); start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); start[0] = 1'b0;
    cyc = 0;
    while (vec[0] != 7'd40 && cyc < 300) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    chk("abort_reach40", vec[0], 40);
    chk("abort_pre_err", err[0], 1);
    rst_n = 1'b0;
    #1;
    chk("abort_vec",   vec[0],   0);
    chk("abort_busy",  busy[0],  0);
    chk("abort_err",   err[0],   0);
    chk("abort_fvec",  fvec[0],  0);
    chk("abort_fresp", fresp[0], 0);
    chk("abort_pass",  pass[0],  0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done[0]) seen++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done[0]) seen++;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_idle", busy[0], 0);

    fault[0] = 2'd0;
    run(0, -1, cyc, bcnt);
    chk("rerun_cycles", cyc, 256);
    chk("rerun_pass",   pass[0], 1);
    chk("rerun_err",    err[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
